// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
//   Shared definitions for the time-multiplexed layer engine and the parallel
//   node blocks: datapath defaults, scheduler state encoding and default
//   address widths.
//   Optional feature macro used by the scheduler: LAYER_SCHED_BACKPRESSURE_EN.
// -----------------------------------------------------------------------------
package layer_pkg;

    localparam int DW_DEF      = 24;    // data / weight / accumulator width
    localparam int OW_DEF      = 8;     // activation output width
    localparam int SAT_LIM_DEF = 8192;  // accumulator saturation threshold
    localparam int SHIFT_DEF   = 5;     // output scale (right shift)
    localparam int N_IN_DEF    = 15;    // inputs per neuron
    localparam int N_NODES_DEF = 8;     // neurons per layer

    // Address widths at the default geometry
    localparam int ACT_AW_DEF = $clog2(N_IN_DEF);
    localparam int W_AW_DEF   = $clog2(N_NODES_DEF * (N_IN_DEF + 1));
    localparam int IDX_W_DEF  = $clog2(N_NODES_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/relu_sat.sv
// -----------------------------------------------------------------------------
// relu_sat
//   Clamp-and-scale activation shared by the scheduler and the parallel node
//   blocks. Negative accumulators give 0, accumulators above SAT_LIM
//   (unsigned compare) give all-ones, anything else is acc[SHIFT+OW-1:SHIFT].
//   acc == SAT_LIM is deliberately not saturated.
//
// Ports
//   acc_i  in   DW  accumulator value (two's complement)
//   act_o  out  OW  activated result
// -----------------------------------------------------------------------------
module relu_sat
    import layer_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int SAT_LIM = SAT_LIM_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic [DW-1:0] acc_i,
    output logic [OW-1:0] act_o
);

    function automatic logic [OW-1:0] clamp_scale(input logic [DW-1:0] a);
        if (a[DW-1]) begin
            return '0;
        end else if (a > DW'(SAT_LIM)) begin
            return '1;
        end else begin
            return a[SHIFT+OW-1:SHIFT];
        end
    endfunction

    assign act_o = clamp_scale(acc_i);

endmodule

// File: rtl/layer_mac_scheduler.sv
// -----------------------------------------------------------------------------
// layer_mac_scheduler
//   One shared multiply-accumulate evaluates N_NODES neurons of N_IN inputs
//   each, one after another: acc = bias + sum(act[k] * w[k]), followed by the
//   relu_sat activation. Reads the activation buffer and the weight ROM (both
//   1-cycle read latency) and writes results toward the next layer.
//   Weight ROM layout: word node*(N_IN+1)+0 = bias, +k = weight k-1.
//
//   Optional feature macro: LAYER_SCHED_BACKPRESSURE_EN
//     defined   : adds out_ready; a result is held in OUT until out_ready=1.
//     undefined : out_valid is an unconditional 1-cycle pulse.
//
// Ports
//   clk        in   1                          clock
//   reset      in   1                          synchronous active-high reset
//   start      in   1                          begin layer (sampled in IDLE)
//   busy       out  1                          layer in progress
//   done       out  1                          1-cycle pulse after last neuron
//   act_addr   out  clog2(N_IN)                activation buffer address
//   act_data   in   DW                         activation word (1 cycle later)
//   w_addr     out  clog2(N_NODES*(N_IN+1))    weight ROM address
//   w_data     in   DW                         weight/bias word (1 cycle later)
//   out_ready  in   1                          (backpressure build only)
//   out_valid  out  1                          neuron result valid
//   out_idx    out  clog2(N_NODES)             neuron index of out_data
//   out_data   out  OW                         activated result
// -----------------------------------------------------------------------------
module layer_mac_scheduler
    import layer_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_NODES = N_NODES_DEF,
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int SAT_LIM = SAT_LIM_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(N_IN)-1:0]               act_addr,
    input  logic [DW-1:0]                         act_data,
    output logic [$clog2(N_NODES*(N_IN+1))-1:0]   w_addr,
    input  logic [DW-1:0]                         w_data,
`ifdef LAYER_SCHED_BACKPRESSURE_EN
    input  logic                                  out_ready,
`endif
    output logic                                  out_valid,
    output logic [$clog2(N_NODES)-1:0]            out_idx,
    output logic [OW-1:0]                         out_data
);

    localparam int AA_W = $clog2(N_IN);
    localparam int WA_W = $clog2(N_NODES * (N_IN + 1));
    localparam int IX_W = $clog2(N_NODES);
    localparam int J_W  = $clog2(N_IN + 1);

    state_e                 state_q, state_d;
    logic [J_W-1:0]         j_q;
    logic [IX_W-1:0]        node_q;
    logic                   last_j, last_node, xfer;

    logic                   vld_p1;   // a ROM/buffer word arrives this cycle
    logic                   bias_p1;  // that word is the bias (j == 0)
    logic signed [DW-1:0]   prod_p1;
    logic signed [DW-1:0]   acc_q;
    logic [OW-1:0]          act_w;

    assign last_j    = (j_q == J_W'(N_IN));
    assign last_node = (node_q == IX_W'(N_NODES - 1));

`ifdef LAYER_SCHED_BACKPRESSURE_EN
    assign xfer = out_ready;
`else
    assign xfer = 1'b1;
`endif

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (last_j) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (xfer) state_d = last_node ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- issue / neuron counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            j_q    <= '0;
            node_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        j_q    <= '0;
                        node_q <= '0;
                    end
                end
                ISSUE: j_q <= last_j ? '0 : j_q + J_W'(1);
                OUT: begin
                    if (xfer && !last_node) begin
                        node_q <= node_q + IX_W'(1);
                        j_q    <= '0;
                    end
                end
                DONE:    node_q <= '0;
                default: ;
            endcase
        end
    end

    // ---- stage p1: memory data returns, accumulate ----
    // Only the low DW bits of the product are kept; the sum wraps mod 2^DW.
    assign prod_p1 = $signed(act_data) * $signed(w_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            bias_p1 <= 1'b0;
            acc_q   <= '0;
        end else begin
            vld_p1  <= (state_q == ISSUE);
            bias_p1 <= (state_q == ISSUE) && (j_q == '0);
            if (vld_p1) begin
                acc_q <= bias_p1 ? $signed(w_data) : acc_q + prod_p1;
            end
        end
    end

    relu_sat #(
        .DW      (DW),
        .OW      (OW),
        .SAT_LIM (SAT_LIM),
        .SHIFT   (SHIFT)
    ) u_act (
        .acc_i (acc_q),
        .act_o (act_w)
    );

    // ---- outputs ----
    // Everything is decoded from the current state so that a reset edge
    // returns all outputs to 0 immediately.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        out_valid = (state_q == OUT);
        out_idx   = '0;
        out_data  = '0;
        w_addr    = '0;
        act_addr  = '0;
        if (state_q == ISSUE) begin
            w_addr = WA_W'(node_q) * WA_W'(N_IN + 1) + WA_W'(j_q);
            if (j_q != '0) begin
                act_addr = AA_W'(j_q - J_W'(1));
            end
        end
        if (state_q == OUT) begin
            out_idx  = node_q;
            out_data = act_w;
        end
    end

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_layer_mac_scheduler
//   Directed layers with hand-computed results. Expected (idx, data) pairs are
//   queued before each layer; a monitor pops and compares on every out_valid
//   transfer and checks output/done latency. Build with
//   LAYER_SCHED_BACKPRESSURE_EN to include the out_ready hold scenario.
// -----------------------------------------------------------------------------
module tb_layer_mac_scheduler;

    localparam int N_IN    = 15;
    localparam int N_NODES = 8;
    localparam int DW      = 24;
    localparam int OW      = 8;
    localparam int WPN     = N_IN + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        act_addr;
    logic [DW-1:0]     act_data;
    logic [6:0]        w_addr;
    logic [DW-1:0]     w_data;
`ifdef LAYER_SCHED_BACKPRESSURE_EN
    logic              out_ready;
`endif
    logic              out_valid;
    logic [2:0]        out_idx;
    logic [OW-1:0]     out_data;

    layer_mac_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
`ifdef LAYER_SCHED_BACKPRESSURE_EN
        .out_ready (out_ready),
`endif
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Activation buffer and weight ROM, 1-cycle read latency
    logic [DW-1:0] act_mem [N_IN];
    logic [DW-1:0] w_mem   [N_NODES*WPN];

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   S      = 0;
    int   n_out  = 0;
    int   n_done = 0;
    int   exp_done_lat = 145;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---- monitor / scoreboard ----
    always @(negedge clk) begin
        exp_t e;
        bit   take;
        take = out_valid;
`ifdef LAYER_SCHED_BACKPRESSURE_EN
        if (out_valid && !out_ready) begin
            take = 1'b0;
            if (exp_q.size() != 0) begin
                check("hold_idx", int'(out_idx), exp_q[0].idx);
                check("hold_data", int'(out_data), exp_q[0].data);
            end else begin
                check("unexpected_hold", 1, 0);
            end
        end
`endif
        if (take) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (n_out == 0) check("first_valid_lat", cyc - S + 1, 18);
                check("out_idx", int'(out_idx), e.idx);
                check("out_data", int'(out_data), e.data);
            end
            n_out++;
        end
        if (done) begin
            n_done++;
            check("done_lat", cyc - S + 1, exp_done_lat);
        end
    end

    // ---- layer setup helpers ----
    task automatic set_acts(input int base, input int step);
        for (int k = 0; k < N_IN; k++) act_mem[k] = DW'(base + step * k);
    endtask

    task automatic set_node(input int n, input logic [DW-1:0] bias,
                            input logic [DW-1:0] w, input int want);
        w_mem[n*WPN] = bias;
        for (int k = 1; k < WPN; k++) w_mem[n*WPN + k] = w;
        exp_q.push_back('{idx: n, data: want});
    endtask

    task automatic set_all(input logic [DW-1:0] bias, input logic [DW-1:0] w,
                           input int want);
        for (int n = 0; n < N_NODES; n++) set_node(n, bias, w, want);
    endtask

    // Runs one layer. Inputs are changed 1 time unit after each clock edge;
    // iteration c sits in the cycle following the edge S+c.
    task automatic run_layer(input int want_outs, input int want_dones,
                             input bit pulses, input int rst_at,
                             input int done_lat, input int hold_at);
        int busy_bad;
        busy_bad     = 0;
        n_out        = 0;
        n_done       = 0;
        exp_done_lat = done_lat;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        S     = cyc;
        start = 1'b0;
        for (int c = 0; c <= done_lat + 4; c++) begin
            if (rst_at == 0 && busy !== (c <= done_lat - 1)) busy_bad++;
            if (rst_at != 0 && c == rst_at) begin
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_idx", int'(out_idx), 0);
                check("rst_out_data", int'(out_data), 0);
                check("rst_w_addr", int'(w_addr), 0);
                check("rst_act_addr", int'(act_addr), 0);
            end
            reset = (rst_at != 0) && (c == rst_at - 1);
            start = pulses && (c == 5 || c == 144);
`ifdef LAYER_SCHED_BACKPRESSURE_EN
            out_ready = !(hold_at != 0 && c >= hold_at && c < hold_at + 10);
`endif
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        check("out_count", n_out, want_outs);
        check("done_count", n_done, want_dones);
        check("queue_left", exp_q.size(), 0);
        check("busy_profile_errors", busy_bad, 0);
        exp_q.delete();
    endtask

    task automatic setup_mixed(input bit push_all);
        // acts 1..15, sum = 120
        set_acts(1, 1);
        set_node(0, 24'd0,       24'd1,       3);    // 120 >> 5
        set_node(1, 24'd8192,    24'd0,       0);    // == SAT_LIM, not saturated
        set_node(2, 24'd8193,    24'd0,       255);  // just above SAT_LIM
        if (!push_all) exp_q = exp_q[0:1];
        w_mem[3*WPN] = 24'hFFFFFB;
        for (int k = 1; k < WPN; k++) w_mem[3*WPN + k] = 24'd0;
        if (push_all) exp_q.push_back('{idx: 3, data: 0});   // -5 clamps to 0
        w_mem[4*WPN] = 24'd0;
        for (int k = 1; k < WPN; k++) w_mem[4*WPN + k] = 24'd2;
        if (push_all) exp_q.push_back('{idx: 4, data: 7});   // 240 >> 5
        w_mem[5*WPN] = 24'd100;
        for (int k = 1; k < WPN; k++) w_mem[5*WPN + k] = 24'd1;
        if (push_all) exp_q.push_back('{idx: 5, data: 6});   // 220 >> 5
        w_mem[6*WPN] = 24'd0;
        for (int k = 1; k < WPN; k++) w_mem[6*WPN + k] = 24'hFFFFFF;
        if (push_all) exp_q.push_back('{idx: 6, data: 0});   // -120 clamps to 0
        w_mem[7*WPN] = 24'd8000;
        for (int k = 1; k < WPN; k++) w_mem[7*WPN + k] = 24'd1;
        if (push_all) exp_q.push_back('{idx: 7, data: 253}); // 8120 >> 5
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef LAYER_SCHED_BACKPRESSURE_EN
        out_ready = 1'b1;
`endif
        for (int k = 0; k < N_IN; k++) act_mem[k] = '0;
        for (int k = 0; k < N_NODES*WPN; k++) w_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_idx", int'(out_idx), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_w_addr", int'(w_addr), 0);
        check("reset_act_addr", int'(act_addr), 0);
        reset = 1'b0;

        // Scale: 15*32 = 480 -> 15; extra start pulses must be ignored
        set_acts(32, 0);
        set_all(24'd0, 24'd1, 15);
        run_layer(8, 1, 1'b1, 0, 145, 0);

        // Negative clamp: bias -5, weights 0
        set_all(24'hFFFFFB, 24'd0, 0);
        run_layer(8, 1, 1'b0, 0, 145, 0);

        // Saturation: 15*1000 = 15000 > 8192
        set_acts(1000, 0);
        set_all(24'd0, 24'd1, 255);
        run_layer(8, 1, 1'b0, 0, 145, 0);

        // Per-neuron mix including the SAT_LIM boundary
        setup_mixed(1'b1);
        run_layer(8, 1, 1'b0, 0, 145, 0);

        // Reset at cycle 40 aborts during neuron 2; then a clean rerun
        setup_mixed(1'b0);
        run_layer(2, 0, 1'b0, 40, 60, 0);
        setup_mixed(1'b1);
        run_layer(8, 1, 1'b0, 0, 145, 0);

`ifdef LAYER_SCHED_BACKPRESSURE_EN
        // Hold neuron 3 for 10 cycles: everything after it shifts by 10
        set_acts(32, 0);
        set_all(24'd0, 24'd1, 15);
        run_layer(8, 1, 1'b0, 0, 155, 71);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Time-multiplexed neuron-layer engine: one shared multiply-accumulate evaluates N_NODES neurons of N_IN inputs each, one neuron after another.
- Each neuron is computed as a bias plus weighted sum, followed by the team's clamp-and-scale activation.
- Sits between the activation buffer and the weight ROM (both with 1-cycle read latency) and the next layer's input buffer.
- Replaces per-neuron parallel node instances where area matters.

Parameters:
- N_IN, 15, inputs per neuron.
- N_NODES, 8, neurons per layer.
- DW, 24, data/weight/accumulator width.
- OW, 8, activation output width.
- SAT_LIM, 8192, saturation threshold; unsigned compare.
- SHIFT, 5, output scale; out = acc[SHIFT+OW-1:SHIFT].

Ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- start  in  1  begin layer; sampled in IDLE only.
- busy  out  1  high from cycle after accepted start until done cycle inclusive.
- done  out  1  1-cycle pulse after last neuron output.
- act_addr  out  clog2(N_IN)  activation buffer read address.
- act_data  in  DW  activation word, valid 1 cycle after act_addr.
- w_addr  out  clog2(N_NODES*(N_IN+1))  weight ROM address; word node*(N_IN+1)+0 = bias, +k = weight k-1.
- w_data  in  DW  weight/bias word, valid 1 cycle after w_addr.
- out_valid  out  1  neuron result valid.
- out_idx  out  clog2(N_NODES)  neuron index of out_data.
- out_data  out  OW  activated result.

Behaviour:
- Reset value of every output: 0. Reset value of internal state: FSM=IDLE, j=0, node=0, acc=0.
- Reset asserted mid-layer: abort within the same edge; no done and no out_valid are produced.
- States: IDLE, ISSUE, DRAIN, OUT, DONE.
- IDLE: start=1 moves to ISSUE with node=0, j=0. start in any other state is ignored.
- ISSUE: runs N_IN+1 cycles, j=0..N_IN.
  - w_addr = node*(N_IN+1)+j.
  - act_addr = j-1 for j>=1; act_addr = 0 for j=0 (don't care).
- Accumulate, in the cycle after each issue (ISSUE with j>=1, and DRAIN):
  - Data for j=0: acc <= w_data (bias load).
  - Data for j>=1: acc <= acc + (act_data*w_data)[DW-1:0].
  - Product is truncated to DW bits; sum wraps modulo 2^DW as two's complement.
- DRAIN: 1 cycle; absorbs the last product, then goes to OUT.
- OUT: out_valid=1 for 1 cycle, out_idx=node, out_data=f(acc).
  - If node<N_NODES-1: node++, j=0, go to ISSUE.
  - Else go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. start seen in DONE is ignored.
- Activation f(acc):
  - acc[DW-1]=1 gives 0.
  - acc > SAT_LIM (unsigned) gives all-ones (255).
  - Otherwise acc[SHIFT+OW-1:SHIFT].
  - Boundary: acc == SAT_LIM is not saturated, so 8192 gives acc[12:5] = 0. This is intended and matches existing nodes.
- Latency:
  - Per neuron: N_IN+3 cycles (18 at defaults).
  - First out_valid: 18 cycles after the start edge.
  - done: N_NODES*(N_IN+3)+1 cycles after the start edge (145).
- out_valid outputs are separated by exactly N_IN+3 cycles; there is no gap between neurons.

Optional Feature:
- Macro LAYER_SCHED_BACKPRESSURE_EN.
- Defined:
  - Adds port out_ready, in, 1.
  - OUT holds out_valid, out_idx and out_data stable until the cycle out_ready=1; transfer occurs on valid&ready.
  - ISSUE of the next neuron starts the cycle after the transfer.
  - busy stays high throughout the hold.
- Undefined:
  - No out_ready port; out_valid is an unconditional 1-cycle pulse with the fixed timing above.

Decomposition:
- Package layer_pkg holds:
  - DW, OW, SAT_LIM, SHIFT defaults.
  - State enum {IDLE, ISSUE, DRAIN, OUT, DONE}.
  - Address-width helper constants.
- Sub-module relu_sat: combinational acc(DW) to out(OW) activation, parameterized by SAT_LIM and SHIFT. It is reused by the parallel node blocks.
- The FSM, counters and accumulator stay in layer_mac_scheduler.

Test Plan:
- Scale check: all act=32, all weights=1, bias=0, start → acc 480 → out_data=15 for idx 0..7; first out_valid 18 cycles after start; done at cycle 145.
- Negative clamp: weights=0, bias=-5 (24'hFFFFFB) → out_data=0 for every neuron.
- Saturation: act=1000, weights=1, bias=0 → acc 15000 → out_data=255. Boundary: bias=8192, weights=0 → out_data=0. Bias=8193 → 255.
- Start ignored: pulse start again at cycles 5 and 144 → still exactly 8 out_valid and one done; busy never drops early.
- Reset mid-layer: assert reset at cycle 40 for 1 cycle → all outputs 0 next cycle, no done. A new start then gives the full correct sequence.
- Backpressure (macro defined): hold out_ready=0 for 10 cycles at neuron 3 → out_data and out_idx stable; neuron 4 ISSUE begins the cycle after the handshake; done delayed by 10 cycles.
